// File: rtl/isqrt_seq_if.sv
// Handshake bundle for isqrt_seq: operand in, root/remainder out.
// The err line exists only when ISQRT_SEQ_CHECK_EN is defined.
interface isqrt_seq_if #(parameter int W = 4);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] sq_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   root;
  logic [2*W-1:0] rem;
  logic           exact;
`ifdef ISQRT_SEQ_CHECK_EN
  logic           err;
`endif

  modport slave (
    input  in_valid, sq_in, out_ready,
    output in_ready, out_valid, root, rem, exact
`ifdef ISQRT_SEQ_CHECK_EN
    , output err
`endif
  );

  modport master (
    output in_valid, sq_in, out_ready,
    input  in_ready, out_valid, root, rem, exact
`ifdef ISQRT_SEQ_CHECK_EN
    , input err
`endif
  );
endinterface

// File: rtl/isqrt_seq.sv
// Sequential integer square root: walks x^2 upward by odd increments, one per clock.
// Optional ISQRT_SEQ_CHECK_EN adds a sticky err output from an independent root^2 accumulator.
module isqrt_seq #(
  parameter int W = 4
) (
  input  logic        clk,
  input  logic        rst,
  isqrt_seq_if.slave  bus
);
  localparam int N2 = 2 * W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    x;
  logic [N2-1:0]   s, n;
  logic [N2:0]     t;
  logic            step;
  logic [N2-1:0]   rem_nx;
  logic [W-1:0]    root_q;
  logic [N2-1:0]   rem_q;
  logic            exact_q, out_valid_q, in_ready_c;

  // One extra bit on t so the (2^W)^2 candidate cannot wrap.
  assign t      = {1'b0, s} + {{(N2-W){1'b0}}, x, 1'b0} + {{N2{1'b0}}, 1'b1};
  assign step   = (x != {W{1'b1}}) && (t <= {1'b0, n});
  assign rem_nx = n - s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN:  if (!step) state_nx = DONE;
      DONE: if (out_valid_q && bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n           <= '0;
      x           <= '0;
      s           <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      exact_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          n <= bus.sq_in;
          x <= '0;
          s <= '0;
        end
        RUN: begin
          if (step) begin
            s <= t[N2-1:0];
            x <= x + 1'b1;
          end else begin
            root_q      <= x;
            rem_q       <= rem_nx;
            exact_q     <= (n == s);
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ISQRT_SEQ_CHECK_EN
  // Shadow square built from x alone, so a fault in s or the step logic shows up here.
  logic [N2-1:0] chk_sq;
  logic [N2-1:0] xe;
  logic          err_q;

  assign xe = {{(N2-W){1'b0}}, x};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_sq <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) chk_sq <= '0;
        RUN: begin
          if (step) chk_sq <= chk_sq + xe + xe + {{(N2-1){1'b0}}, 1'b1};
          else if ((({1'b0, chk_sq} + {1'b0, rem_nx}) != {1'b0, n}) ||
                   (rem_nx > {{(N2-W-1){1'b0}}, x, 1'b0}))
            err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.err = err_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.root      = root_q;
  assign bus.rem       = rem_q;
  assign bus.exact     = exact_q;
endmodule

// File: tb/tb_isqrt_seq.sv
// Directed bench for isqrt_seq (W=4): hand-computed vectors, back-pressure,
// async reset mid-operation, and an invariant sweep over every 8-bit operand.
module tb_isqrt_seq;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  isqrt_seq_if #(.W(W)) bus ();
  isqrt_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accept n, count edges to out_valid, optionally poke in_valid during RUN.
  task automatic start_op(input logic [7:0] n, input bit noise, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sq_in    = n;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      if (noise) begin
        bus.in_valid = ~bus.in_valid;
        bus.sq_in    = 8'd100;
      end
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) chk("timeout", 0, 1);
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("drain_ov", bus.out_valid, 0);
    chk("drain_ir", bus.in_ready, 1);
  endtask

  task automatic op(input string tag, input logic [7:0] n, input int er, input int erem,
                    input int eex, input int elat, input bit noise);
    int lat;
    start_op(n, noise, lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_root"}, bus.root, er);
    chk({tag, "_rem"}, bus.rem, erem);
    chk({tag, "_exact"}, bus.exact, eex);
    drain();
  endtask

  initial begin
    int lat;
    int r, m;
    bus.in_valid  = 1'b0;
    bus.sq_in     = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_ir", bus.in_ready, 1);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_root", bus.root, 0);
    chk("rst_rem", bus.rem, 0);
    chk("rst_exact", bus.exact, 0);
    @(negedge clk);
    rst = 1'b0;

    op("n0",   8'd0,   0,  0,  1, 1,  0);
    op("n16",  8'd16,  4,  0,  1, 5,  0);
    op("n15",  8'd15,  3,  6,  0, 4,  0);
    op("n255", 8'd255, 15, 30, 0, 16, 1);
    op("n225", 8'd225, 15, 0,  1, 16, 0);

    // Hold the result under back-pressure.
    start_op(8'd50, 0, lat);
    chk("in_ready_done", bus.in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("hold_ov", bus.out_valid, 1);
      chk("hold_root", bus.root, 7);
      chk("hold_rem", bus.rem, 1);
      chk("hold_exact", bus.exact, 0);
    end
    drain();

    // Async reset in the middle of RUN, away from any clock edge.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sq_in    = 8'd200;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("run_ir", bus.in_ready, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ir", bus.in_ready, 1);
    chk("arst_ov", bus.out_valid, 0);
    chk("arst_root", bus.root, 0);
    chk("arst_rem", bus.rem, 0);
    chk("arst_exact", bus.exact, 0);
    @(negedge clk);
    rst = 1'b0;
    op("n200", 8'd200, 14, 4, 0, 15, 0);

    // Every operand with random back-pressure on the result.
    for (int nn = 0; nn < 256; nn++) begin
      start_op(8'(nn), 0, lat);
      r = int'(bus.root);
      m = int'(bus.rem);
      chk("sweep_sum", r * r + m, nn);
      chk("sweep_rem_le", (m <= 2 * r) ? 1 : 0, 1);
      chk("sweep_exact", bus.exact, (m == 0) ? 1 : 0);
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        bus.out_ready = (k == 49) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (bus.out_ready) break;
        chk("bp_ov", bus.out_valid, 1);
      end
      bus.out_ready = 1'b0;
      chk("sweep_drain", bus.out_valid, 0);
    end
`ifdef ISQRT_SEQ_CHECK_EN
    chk("err", bus.err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
